// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer: program load, run/halt/single-step and restart of the 3-stage pipeline.
// Optional watchdog enabled with `define PIPE_WDT_EN.
module pipe_run_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              wb_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  output logic              pipe_en,
  output logic              pipe_flush,
  output logic              pc_rst,
  output logic [2:0]        state,
  output logic [15:0]       instr_cnt,
  output logic              load_err,
  output logic              wdt_trip
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4,
    S_STEP  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_step_d;
  logic                r_ld_ready;
  logic                r_pipe_en;
  logic                r_pipe_flush;
  logic                r_pc_rst;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_waddr;
  logic [DATA_W-1:0]   r_imem_wdata;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_load_err;
  logic [CNT_W-1:0]    r_instr_cnt;
  logic                w_accept;
  logic                w_step_rise;
  logic                w_load_entry;
  logic                w_wdt_fire;
  logic                w_ld_ready_nxt;
  logic                w_pipe_en_nxt;
  logic                w_prime_nxt;

  assign w_accept     = r_ld_ready & ld_valid;
  assign w_step_rise  = step & ~r_step_d;
  assign w_load_entry = (r_state != S_LOAD) && (w_next == S_LOAD);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and next-output decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ld_valid)                    w_next = S_LOAD;
               else if (start)                  w_next = S_PRIME;
      S_LOAD:  if (w_accept && ld_last)         w_next = S_IDLE;
      S_PRIME:                                  w_next = S_RUN;
      S_RUN:   if (halt_req || w_wdt_fire)      w_next = S_HALT;
               else if (start)                  w_next = S_PRIME;
      S_HALT:  if (start)                       w_next = S_PRIME;
               else if (w_step_rise)            w_next = S_STEP;
               else if (ld_valid)               w_next = S_LOAD;
      S_STEP:                                   w_next = S_HALT;
      default:                                  w_next = S_IDLE;
    endcase
    w_ld_ready_nxt = (w_next == S_LOAD);
    w_pipe_en_nxt  = (w_next == S_RUN) || (w_next == S_STEP);
    w_prime_nxt    = (w_next == S_PRIME);
  end

  // Moore outputs registered from the next state so they line up with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_ready   <= 1'b0;
      r_pipe_en    <= 1'b0;
      r_pipe_flush <= 1'b0;
      r_pc_rst     <= 1'b0;
      r_step_d     <= 1'b0;
    end else begin
      r_ld_ready   <= w_ld_ready_nxt;
      r_pipe_en    <= w_pipe_en_nxt;
      r_pipe_flush <= w_prime_nxt;
      r_pc_rst     <= w_prime_nxt;
      r_step_d     <= step;
    end
  end

  // Program-load write port; address restarts and error clears on each LOAD entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_imem_we    <= 1'b0;
      r_imem_waddr <= '0;
      r_imem_wdata <= '0;
      r_ptr        <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_imem_we <= w_accept;
      if (w_accept) begin
        r_imem_waddr <= r_ptr;
        r_imem_wdata <= ld_data;
        r_ptr        <= r_ptr + ADDR_W'(1);
        if (r_ptr == '1) r_load_err <= 1'b1;
      end else if (w_load_entry) begin
        r_ptr      <= '0;
        r_load_err <= 1'b0;
      end
    end
  end

  // Retired-instruction counter, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_cnt <= '0;
    end else if (r_state == S_PRIME) begin
      r_instr_cnt <= '0;
    end else if (r_pipe_en && wb_valid && (r_instr_cnt != '1)) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_WDT_EN
  logic [CNT_W-1:0] r_wdt_cnt;
  logic             r_wdt_trip;

  // Fires on the RUN cycle in which the counter reaches MAX_CYCLES
  assign w_wdt_fire = (r_state == S_RUN) && ((r_wdt_cnt + CNT_W'(1)) == MAX_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (r_state == S_PRIME) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
      if (w_wdt_fire) r_wdt_trip <= 1'b1;
    end
  end

  assign wdt_trip = r_wdt_trip;
`else
  logic w_unused_max;
  assign w_unused_max = ^MAX_CYCLES;
  assign w_wdt_fire   = 1'b0;
  assign wdt_trip     = 1'b0;
`endif

  assign state      = r_state;
  assign ld_ready   = r_ld_ready;
  assign pipe_en    = r_pipe_en;
  assign pipe_flush = r_pipe_flush;
  assign pc_rst     = r_pc_rst;
  assign imem_we    = r_imem_we;
  assign imem_waddr = r_imem_waddr;
  assign imem_wdata = r_imem_wdata;
  assign instr_cnt  = r_instr_cnt;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed self-checking bench for pipe_run_ctrl: load, wrap, run/count, halt/step, reset, restart, watchdog.
module tb_pipe_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, step, halt_req;
  logic        ld_valid, ld_last, wb_valid;
  logic [7:0]  ld_data;
  logic        ld_ready, imem_we, pipe_en, pipe_flush, pc_rst, load_err, wdt_trip;
  logic [7:0]  imem_waddr, imem_wdata;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  int total = 0;
  int bad   = 0;

  pipe_run_ctrl #(.ADDR_W(8), .MAX_CYCLES(16'd20)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .wb_valid(wb_valid), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pipe_en(pipe_en), .pipe_flush(pipe_flush),
    .pc_rst(pc_rst), .state(state), .instr_cnt(instr_cnt), .load_err(load_err),
    .wdt_trip(wdt_trip)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] all_outs();
    return {state, ld_ready, imem_we, imem_waddr, imem_wdata, pipe_en,
            pipe_flush, pc_rst, instr_cnt, load_err, wdt_trip};
  endfunction

  task automatic test_reset;
    reset = 1'b0; start = 0; step = 0; halt_req = 0;
    ld_valid = 0; ld_last = 0; wb_valid = 0; ld_data = 8'h00;
    #3;
    total++;
    if (all_outs() !== 42'd0) begin
      bad++; $display("FAIL reset_values: got %h exp 0", all_outs());
    end
    tick; tick;
    reset = 1'b1;
    tick;
    total++;
    if (all_outs() !== 42'd0) begin
      bad++; $display("FAIL idle_after_reset: got %h exp 0", all_outs());
    end
  endtask

  task automatic test_load4;
    logic [7:0] v [4];
    v = '{8'h41, 8'h82, 8'hC3, 8'h04};
    ld_valid = 1; start = 1; ld_data = v[0]; ld_last = 0;
    tick;
    start = 0;
    total++;
    if ({state, ld_ready, imem_we} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL load_enter_prio: got %b exp %b", {state, ld_ready, imem_we}, {3'd1, 1'b1, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      ld_data = v[i]; ld_last = (i == 3);
      tick;
      total++;
      if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'(i), v[i]}) begin
        bad++; $display("FAIL load4_beat%0d: got %h exp %h", i, {imem_we, imem_waddr, imem_wdata}, {1'b1, 8'(i), v[i]});
      end
    end
    ld_valid = 0; ld_last = 0;
    total++;
    if ({state, ld_ready, load_err} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL load4_done: got %b exp %b", {state, ld_ready, load_err}, {3'd0, 1'b0, 1'b0});
    end
    tick;
    total++;
    if (imem_we !== 1'b0) begin
      bad++; $display("FAIL load4_we_drop: got %b exp 0", imem_we);
    end
  endtask

  task automatic test_load_wrap;
    ld_valid = 1; ld_last = 0; ld_data = 8'h00;
    tick;
    for (int i = 0; i < 257; i++) begin
      ld_data = 8'(i) ^ 8'h5A; ld_last = (i == 256);
      tick;
      total++;
      if ({imem_we, imem_waddr} !== {1'b1, 8'(i)}) begin
        bad++; $display("FAIL wrap_addr%0d: got %h exp %h", i, {imem_we, imem_waddr}, {1'b1, 8'(i)});
      end
      if (i == 254) begin
        total++;
        if (load_err !== 1'b0) begin
          bad++; $display("FAIL wrap_err_early: got %b exp 0", load_err);
        end
      end
    end
    ld_valid = 0; ld_last = 0;
    total++;
    if ({state, imem_wdata, load_err} !== {3'd0, 8'h5A, 1'b1}) begin
      bad++; $display("FAIL wrap_final: got %h exp %h", {state, imem_wdata, load_err}, {3'd0, 8'h5A, 1'b1});
    end
  endtask

  task automatic test_run_count;
    start = 1;
    tick;
    start = 0;
    total++;
    if ({state, pc_rst, pipe_flush, pipe_en} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL prime: got %b exp %b", {state, pc_rst, pipe_flush, pipe_en}, {3'd2, 1'b1, 1'b1, 1'b0});
    end
    tick;
    total++;
    if ({state, pc_rst, pipe_flush, pipe_en, instr_cnt} !== {3'd3, 1'b0, 1'b0, 1'b1, 16'd0}) begin
      bad++; $display("FAIL run_enter: got %h exp %h", {state, pc_rst, pipe_flush, pipe_en, instr_cnt}, {3'd3, 1'b0, 1'b0, 1'b1, 16'd0});
    end
    wb_valid = 1;
    repeat (10) tick;
    wb_valid = 0;
    total++;
    if ({state, instr_cnt} !== {3'd3, 16'd10}) begin
      bad++; $display("FAIL run_count10: got %h exp %h", {state, instr_cnt}, {3'd3, 16'd10});
    end
  endtask

  task automatic test_halt_step;
    int n_en;
    halt_req = 1; start = 1;
    tick;
    halt_req = 0; start = 0;
    total++;
    if ({state, pipe_en} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL halt_wins: got %b exp %b", {state, pipe_en}, {3'd4, 1'b0});
    end
    tick;
    total++;
    if ({state, instr_cnt} !== {3'd4, 16'd10}) begin
      bad++; $display("FAIL halt_hold: got %h exp %h", {state, instr_cnt}, {3'd4, 16'd10});
    end
    n_en = 0;
    step = 1; wb_valid = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) step = 0;
      tick;
      if (pipe_en === 1'b1) n_en++;
    end
    wb_valid = 0;
    total++;
    if (n_en !== 1) begin
      bad++; $display("FAIL step_once: got %0d exp 1", n_en);
    end
    total++;
    if ({state, instr_cnt} !== {3'd4, 16'd11}) begin
      bad++; $display("FAIL step_count: got %h exp %h", {state, instr_cnt}, {3'd4, 16'd11});
    end
    step = 1;
    tick;
    step = 0;
    total++;
    if ({state, pipe_en} !== {3'd5, 1'b1}) begin
      bad++; $display("FAIL step_again: got %b exp %b", {state, pipe_en}, {3'd5, 1'b1});
    end
    tick;
    total++;
    if ({state, pipe_en} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL step_back: got %b exp %b", {state, pipe_en}, {3'd4, 1'b0});
    end
  endtask

  task automatic test_reset_in_load;
    ld_valid = 1; ld_data = 8'hAA; ld_last = 0;
    tick;
    total++;
    if ({state, ld_ready, load_err} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL halt_to_load: got %b exp %b", {state, ld_ready, load_err}, {3'd1, 1'b1, 1'b0});
    end
    tick;
    ld_data = 8'hBB; start = 1; step = 1; halt_req = 1;
    tick;
    total++;
    if ({state, imem_we, imem_waddr, imem_wdata} !== {3'd1, 1'b1, 8'd1, 8'hBB}) begin
      bad++; $display("FAIL load_ignores_ctl: got %h exp %h", {state, imem_we, imem_waddr, imem_wdata}, {3'd1, 1'b1, 8'd1, 8'hBB});
    end
    reset = 0; ld_valid = 0; start = 0; step = 0; halt_req = 0;
    #2;
    total++;
    if (all_outs() !== 42'd0) begin
      bad++; $display("FAIL async_reset: got %h exp 0", all_outs());
    end
    tick;
    reset = 1;
    ld_valid = 1; ld_data = 8'hCC; ld_last = 1;
    tick;
    tick;
    ld_valid = 0; ld_last = 0;
    total++;
    if ({state, imem_we, imem_waddr, imem_wdata} !== {3'd0, 1'b1, 8'd0, 8'hCC}) begin
      bad++; $display("FAIL fresh_load: got %h exp %h", {state, imem_we, imem_waddr, imem_wdata}, {3'd0, 1'b1, 8'd0, 8'hCC});
    end
  endtask

  task automatic test_restart;
    start = 1;
    tick;
    start = 0;
    tick;
    wb_valid = 1;
    repeat (3) tick;
    wb_valid = 0; start = 1;
    tick;
    start = 0;
    total++;
    if ({state, instr_cnt} !== {3'd2, 16'd3}) begin
      bad++; $display("FAIL restart_prime: got %h exp %h", {state, instr_cnt}, {3'd2, 16'd3});
    end
    tick;
    total++;
    if ({state, pipe_en, instr_cnt} !== {3'd3, 1'b1, 16'd0}) begin
      bad++; $display("FAIL restart_clear: got %h exp %h", {state, pipe_en, instr_cnt}, {3'd3, 1'b1, 16'd0});
    end
    halt_req = 1;
    tick;
    halt_req = 0;
    total++;
    if ({state, pipe_en, wdt_trip} !== {3'd4, 1'b0, 1'b0}) begin
      bad++; $display("FAIL restart_halt: got %b exp %b", {state, pipe_en, wdt_trip}, {3'd4, 1'b0, 1'b0});
    end
  endtask

`ifdef PIPE_WDT_EN
  task automatic test_wdt;
    int n_run;
    start = 1;
    tick;
    start = 0;
    tick;
    n_run = 0;
    for (int i = 0; i < 100 && state === 3'd3; i++) begin
      n_run++;
      tick;
    end
    total++;
    if ({state, wdt_trip} !== {3'd4, 1'b1} || n_run !== 20) begin
      bad++; $display("FAIL wdt_fire: got state=%0d trip=%b runs=%0d exp state=4 trip=1 runs=20", state, wdt_trip, n_run);
    end
    start = 1;
    tick;
    start = 0;
    total++;
    if ({state, wdt_trip} !== {3'd2, 1'b0}) begin
      bad++; $display("FAIL wdt_clear: got %b exp %b", {state, wdt_trip}, {3'd2, 1'b0});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_load4;
    test_load_wrap;
    test_run_count;
    test_halt_step;
    test_reset_in_load;
    test_restart;
`ifdef PIPE_WDT_EN
    test_wdt;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
